// File: rtl/fifo_rptr_empty_fwft_if.sv
// Read-side bus of the async FIFO: sync'd write pointer, memory port and FWFT output handshake.
// "master" is the read controller, "slave" is the memory/consumer side.
interface fifo_rptr_empty_fwft_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 2);

    logic [PTR_W-1:0]  RQ2_WPTR;
    logic [DATA_W-1:0] RDATA_MEM;
    logic              OUT_READY;
    logic [PTR_W-1:0]  RPTR;
    logic [ADDR_W-1:0] RADDR;
    logic              REMPTY;
    logic              OUT_VALID;
    logic [DATA_W-1:0] OUT_DATA;
    logic [LVL_W-1:0]  RLEVEL;

    modport master (
        input  RQ2_WPTR, RDATA_MEM, OUT_READY,
        output RPTR, RADDR, REMPTY, OUT_VALID, OUT_DATA, RLEVEL
    );

    modport slave (
        output RQ2_WPTR, RDATA_MEM, OUT_READY,
        input  RPTR, RADDR, REMPTY, OUT_VALID, OUT_DATA, RLEVEL
    );
endinterface

// File: rtl/fifo_rptr_empty_fwft.sv
// Async FIFO read pointer / empty detect with a one-entry first-word-fall-through output register.
// Define FIFO_RLEVEL_EN to register an occupancy count on RLEVEL; otherwise RLEVEL is tied to 0.
module fifo_rptr_empty_fwft #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32
) (
    input logic                    RCLK,
    input logic                    RRST,
    fifo_rptr_empty_fwft_if.master bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0]  rptr_bin_q, rptr_bin_d;
    logic [PTR_W-1:0]  rptr_gray_q, rptr_gray_d;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              rempty;
    logic              pop;

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    always_comb begin
        rempty      = (rptr_gray_q == bus.RQ2_WPTR);
        // Refill whenever the output register is free or being drained this cycle.
        pop         = ~rempty & (~out_valid_q | bus.OUT_READY);
        rptr_bin_d  = rptr_bin_q + 1'b1;
        rptr_gray_d = bin2gray(rptr_bin_d);
    end

    always_ff @(posedge RCLK or posedge RRST) begin
        if (RRST) begin
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (pop) begin
                rptr_bin_q  <= rptr_bin_d;
                rptr_gray_q <= rptr_gray_d;
                out_data_q  <= bus.RDATA_MEM;
                out_valid_q <= 1'b1;
            end else if (bus.OUT_READY) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.RPTR      = rptr_gray_q;
    assign bus.RADDR     = rptr_bin_q[ADDR_W-1:0];
    assign bus.REMPTY    = rempty;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = out_data_q;

`ifdef FIFO_RLEVEL_EN
    localparam int unsigned LVL_W = $clog2(DEPTH + 2);

    logic [PTR_W-1:0] wptr_bin;
    logic [PTR_W-1:0] mem_level;
    logic [LVL_W-1:0] level_q;

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < PTR_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    always_comb begin
        wptr_bin  = gray2bin(bus.RQ2_WPTR);
        mem_level = wptr_bin - rptr_bin_q;
    end

    // Memory words plus the word parked in the output register; lags state by one cycle.
    always_ff @(posedge RCLK or posedge RRST) begin
        if (RRST) begin
            level_q <= '0;
        end else begin
            level_q <= LVL_W'(mem_level) + LVL_W'(out_valid_q);
        end
    end

    assign bus.RLEVEL = level_q;
`else
    assign bus.RLEVEL = '0;
`endif
endmodule
